// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus operand select for the ALU.
// Latency: ID fields appear at the EX outputs one cycle after capture. EX/MEM and
//   MEM/WB forwarding onto In1/In2/ex_store_data is combinational, in the same cycle.
// Backpressure: stall holds every register. hazard_stall (load-use) asks ID to hold
//   while a bubble is loaded. flush overrides both and loads a bubble.
// Ports:
//   clk, rst_n               clock and synchronous active-low reset
//   id_*                     decoded instruction fields from ID
//   stall, flush             downstream hold / kill of the instruction being captured
//   exmem_*, memwb_*         write-back info from later stages, used for forwarding
//   hazard_stall             load-use stall request to PC and IF/ID
//   ex_valid, In1, In2       EX instruction valid flag and ALU operands
//   ALUOP, shamt             registered ALU opcode and shift amount
//   ex_store_data, ex_dest   forwarded rt for stores, write-back register number
//   ex_regwrite/memread/memwrite/branch  registered controls
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic [REG_W-1:0]  id_rd,
   input  logic [15:0]       id_imm,
   input  logic              id_signext,
   input  logic [4:0]        id_shamt,
   input  logic [2:0]        id_aluop,
   input  logic              id_alusrc,
   input  logic              id_regdst,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic [1:0]        id_branch,
   input  logic              stall,
   input  logic              flush,
   input  logic              exmem_regwrite,
   input  logic [REG_W-1:0]  exmem_rd,
   input  logic [DATA_W-1:0] exmem_result,
   input  logic              memwb_regwrite,
   input  logic [REG_W-1:0]  memwb_rd,
   input  logic [DATA_W-1:0] memwb_result,
   output logic              hazard_stall,
   output logic              ex_valid,
   output logic [DATA_W-1:0] In1,
   output logic [DATA_W-1:0] In2,
   output logic [2:0]        ALUOP,
   output logic [4:0]        shamt,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_W-1:0]  ex_dest,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic [1:0]        ex_branch
);

   // Registered source fields needed for forwarding and operand select.
   logic [REG_W-1:0]  rs_q;
   logic [REG_W-1:0]  rt_q;
   logic [DATA_W-1:0] rs_data_q;
   logic [DATA_W-1:0] rt_data_q;
   logic [15:0]       imm_q;
   logic              signext_q;
   logic              alusrc_q;

   logic              uses_rt;
   logic              load_bubble;
   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic [DATA_W-1:0] ext_imm;

   // rt is a real source for R-type ops, stores (data) and branches (compare).
   assign uses_rt = !id_alusrc || id_memwrite || (id_branch != 2'b00);

   always_comb begin
      hazard_stall = 1'b0;
      if (!flush && id_valid && ex_valid && ex_memread && (ex_dest != '0)) begin
         hazard_stall = (ex_dest == id_rs) || ((ex_dest == id_rt) && uses_rt);
      end
   end

   // Reset, flush and an unstalled load-use bubble all clear the register.
   // A bubble under stall is not taken: the stall holds the load in EX instead.
   assign load_bubble = !rst_n || flush || (!stall && hazard_stall);

   always_ff @(posedge clk) begin
      if (load_bubble) begin
         ex_valid    <= 1'b0;
         rs_q        <= '0;
         rt_q        <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
         signext_q   <= 1'b0;
         alusrc_q    <= 1'b0;
         ALUOP       <= '0;
         shamt       <= '0;
         ex_dest     <= '0;
         ex_regwrite <= 1'b0;
         ex_memread  <= 1'b0;
         ex_memwrite <= 1'b0;
         ex_branch   <= '0;
      end else if (!stall) begin
         ex_valid    <= id_valid;
         rs_q        <= id_rs;
         rt_q        <= id_rt;
         rs_data_q   <= id_rs_data;
         rt_data_q   <= id_rt_data;
         imm_q       <= id_imm;
         signext_q   <= id_signext;
         alusrc_q    <= id_alusrc;
         ALUOP       <= id_aluop;
         shamt       <= id_shamt;
         ex_dest     <= id_regdst ? id_rd : id_rt;
         ex_regwrite <= id_regwrite;
         ex_memread  <= id_memread;
         ex_memwrite <= id_memwrite;
         ex_branch   <= id_branch;
      end
   end

   // Forwarding: the younger EX/MEM result wins over MEM/WB; $0 never forwards.
   always_comb begin
      fwd_rs = rs_data_q;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
         fwd_rs = exmem_result;
      end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
         fwd_rs = memwb_result;
      end
   end

   always_comb begin
      fwd_rt = rt_data_q;
      if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
         fwd_rt = exmem_result;
      end else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
         fwd_rt = memwb_result;
      end
   end

   assign ext_imm       = {{(DATA_W-16){imm_q[15] & signext_q}}, imm_q};
   assign In1           = fwd_rs;
   assign In2           = alusrc_q ? ext_imm : fwd_rt;
   assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_rs_data, id_rt_data;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [15:0] id_imm;
   logic        id_signext;
   logic [4:0]  id_shamt;
   logic [2:0]  id_aluop;
   logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite;
   logic [1:0]  id_branch;
   logic        stall, flush;
   logic        exmem_regwrite, memwb_regwrite;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic        hazard_stall, ex_valid;
   logic [31:0] In1, In2, ex_store_data;
   logic [2:0]  ALUOP;
   logic [4:0]  shamt;
   logic [4:0]  ex_dest;
   logic        ex_regwrite, ex_memread, ex_memwrite;
   logic [1:0]  ex_branch;

   id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
      .id_signext(id_signext), .id_shamt(id_shamt), .id_aluop(id_aluop),
      .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
      .id_memread(id_memread), .id_memwrite(id_memwrite), .id_branch(id_branch),
      .stall(stall), .flush(flush),
      .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .hazard_stall(hazard_stall), .ex_valid(ex_valid), .In1(In1), .In2(In2),
      .ALUOP(ALUOP), .shamt(shamt), .ex_store_data(ex_store_data), .ex_dest(ex_dest),
      .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_branch(ex_branch)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: what instruction EX holds. data_known is cleared by a bubble,
   // whose datapath contents are not defined, so operands are then not compared.
   typedef struct {
      logic        valid, data_known;
      logic [4:0]  rs, rt, dest, shamt;
      logic [31:0] rs_data, rt_data;
      logic [15:0] imm;
      logic        signext, alusrc, regwrite, memread, memwrite;
      logic [2:0]  aluop;
      logic [1:0]  branch;
   } ex_t;
   ex_t m;

   function automatic logic exp_hazard();
      logic reads_rt;
      reads_rt = (id_alusrc == 1'b0) || id_memwrite || (id_branch != 0);
      if (flush || !id_valid || !m.valid || !m.memread || m.dest == 0) return 1'b0;
      return (m.dest == id_rs) || (reads_rt && m.dest == id_rt);
   endfunction

   function automatic logic [31:0] exp_src(input logic [4:0] r, input logic [31:0] d);
      if (r == 0) return d;
      if (exmem_regwrite && exmem_rd == r) return exmem_result;
      if (memwb_regwrite && memwb_rd == r) return memwb_result;
      return d;
   endfunction

   function automatic logic [31:0] exp_imm();
      if (m.signext && m.imm[15]) return 32'hFFFF_0000 + 32'(m.imm);
      return 32'(m.imm);
   endfunction

   // Called right after a rising edge with the inputs that were present at it.
   task automatic model_step(input logic hz);
      ex_t z;
      z = '{default: '0};
      if (!rst_n) begin
         m = z;
         m.data_known = 1'b1;
      end else if (flush || (!stall && hz)) begin
         m = z;
      end else if (!stall) begin
         m.valid = id_valid; m.data_known = 1'b1;
         m.rs = id_rs; m.rt = id_rt; m.dest = id_regdst ? id_rd : id_rt;
         m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
         m.signext = id_signext; m.alusrc = id_alusrc; m.shamt = id_shamt;
         m.aluop = id_aluop; m.regwrite = id_regwrite; m.memread = id_memread;
         m.memwrite = id_memwrite; m.branch = id_branch;
      end
   endtask

   task automatic check_all();
      chk("hazard_stall", 32'(hazard_stall), 32'(exp_hazard()));
      chk("ex_valid", 32'(ex_valid), 32'(m.valid));
      chk("ex_dest", 32'(ex_dest), 32'(m.dest));
      chk("ex_regwrite", 32'(ex_regwrite), 32'(m.regwrite));
      chk("ex_memread", 32'(ex_memread), 32'(m.memread));
      chk("ex_memwrite", 32'(ex_memwrite), 32'(m.memwrite));
      chk("ex_branch", 32'(ex_branch), 32'(m.branch));
      if (m.data_known) begin
         chk("ALUOP", 32'(ALUOP), 32'(m.aluop));
         chk("shamt", 32'(shamt), 32'(m.shamt));
         chk("In1", In1, exp_src(m.rs, m.rs_data));
         chk("In2", In2, m.alusrc ? exp_imm() : exp_src(m.rt, m.rt_data));
         chk("store_data", ex_store_data, exp_src(m.rt, m.rt_data));
      end
   endtask

   // Entered just after a falling edge; checks, clocks, leaves after the next falling edge.
   task automatic tick();
      logic hz;
      #1;
      check_all();
      hz = exp_hazard();
      @(posedge clk);
      model_step(hz);
      @(negedge clk);
   endtask

   task automatic id_idle();
      id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_rs = 0; id_rt = 0; id_rd = 0;
      id_imm = 0; id_signext = 0; id_shamt = 0; id_aluop = 0; id_alusrc = 0;
      id_regdst = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0; id_branch = 0;
   endtask

   task automatic rand_inputs();
      id_valid = 1'($urandom); id_rs_data = $urandom; id_rt_data = $urandom;
      id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3)); id_imm = 16'($urandom);
      id_signext = 1'($urandom); id_shamt = 5'($urandom); id_aluop = 3'($urandom);
      id_alusrc = 1'($urandom); id_regdst = 1'($urandom); id_regwrite = 1'($urandom);
      id_memread = ($urandom_range(0, 2) == 0); id_memwrite = 1'($urandom);
      id_branch = 2'($urandom_range(0, 2));
      exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3));
      exmem_result = $urandom;
      memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3));
      memwb_result = $urandom;
   endtask

   task automatic fwd_idle();
      exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   initial begin
      m = '{default: '0};
      rst_n = 0; stall = 0; flush = 0;
      id_idle(); fwd_idle();

      // Reset for two cycles with a valid instruction and random fields in ID.
      @(negedge clk);
      rand_inputs(); id_valid = 1;
      @(posedge clk);
      model_step(1'b0);
      @(negedge clk);
      rand_inputs(); id_valid = 1; id_memread = 1;
      tick();
      fwd_idle();
      #1;
      chk("rst_ex_valid", 32'(ex_valid), 32'd0);
      chk("rst_ALUOP", 32'(ALUOP), 32'd0);
      chk("rst_ex_dest", 32'(ex_dest), 32'd0);
      chk("rst_hazard", 32'(hazard_stall), 32'd0);
      rst_n = 1;

      // ADDI pass-through, sign- then zero-extended immediate.
      id_idle();
      id_valid = 1; id_rs = 1; id_rt = 2; id_rs_data = 5; id_imm = 16'hFFFE;
      id_signext = 1; id_alusrc = 1; id_regwrite = 1;
      tick();
      id_signext = 0;
      #1;
      chk("addi_In1", In1, 32'd5);
      chk("addi_In2_sx", In2, 32'hFFFF_FFFE);
      chk("addi_ALUOP", 32'(ALUOP), 32'd0);
      tick();
      #1;
      chk("addi_In2_zx", In2, 32'h0000_FFFE);

      // Forwarding priority on rs=3.
      id_idle();
      id_valid = 1; id_rs = 3; id_rt = 4; id_rs_data = 32'h11; id_aluop = 3'd2;
      tick();
      id_idle();
      exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'hAA;
      memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hBB;
      #1 chk("fwd_exmem", In1, 32'hAA);
      exmem_regwrite = 0;
      #1 chk("fwd_memwb", In1, 32'hBB);
      exmem_regwrite = 1; exmem_rd = 0; memwb_rd = 0;
      #1 chk("fwd_none", In1, 32'h11);
      tick();
      fwd_idle();

      // Load-use: LW $8 in EX, ADD reading $8 in ID.
      id_idle();
      id_valid = 1; id_rs = 1; id_rt = 8; id_alusrc = 1; id_memread = 1; id_regwrite = 1;
      tick();
      id_idle();
      id_valid = 1; id_rs = 8; id_rt = 2; id_rd = 9; id_regdst = 1; id_regwrite = 1;
      id_rs_data = 32'h77;
      #1 chk("lu_hazard", 32'(hazard_stall), 32'd1);
      tick();
      #1;
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      chk("lu_hazard_clear", 32'(hazard_stall), 32'd0);
      tick();
      id_idle();
      memwb_regwrite = 1; memwb_rd = 8; memwb_result = 32'hCAFE;
      #1;
      chk("lu_add_valid", 32'(ex_valid), 32'd1);
      chk("lu_add_dest", 32'(ex_dest), 32'd9);
      chk("lu_add_In1", In1, 32'hCAFE);
      tick();
      fwd_idle();

      // Stall holds for three cycles while ID changes; flush beats stall.
      id_idle();
      id_valid = 1; id_rs = 2; id_rt = 3; id_rd = 5; id_regdst = 1; id_regwrite = 1;
      id_rs_data = 32'h1234_5678; id_aluop = 3'd5; id_shamt = 5'd7;
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         rand_inputs(); fwd_idle();
         #1 chk("stall_hold_In1", In1, 32'h1234_5678);
         tick();
      end
      flush = 1;
      tick();
      #1 chk("stall_flush_valid", 32'(ex_valid), 32'd0);
      stall = 0; flush = 0;

      // Store: immediate on In2, forwarded rt on ex_store_data.
      id_idle();
      id_valid = 1; id_rs = 1; id_rt = 9; id_imm = 16'h0010; id_signext = 1;
      id_alusrc = 1; id_memwrite = 1; id_rt_data = 32'h5555;
      tick();
      id_idle();
      exmem_regwrite = 1; exmem_rd = 9; exmem_result = 32'h1234;
      #1;
      chk("sw_In2", In2, 32'h10);
      chk("sw_store_data", ex_store_data, 32'h1234);
      tick();

      // Randomized traffic against the model.
      for (int i = 0; i < 2000; i++) begin
         rand_inputs();
         rst_n = ($urandom_range(0, 49) != 0);
         stall = ($urandom_range(0, 9) == 0);
         flush = ($urandom_range(0, 9) == 0);
         tick();
      end
      rst_n = 1; stall = 0; flush = 0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage; sits directly upstream of the ALU and drives its In1, In2, ALUOP and shamt inputs.
- Registers decoded fields from ID and forwards EX/MEM and MEM/WB results onto the ALU operands.
- Detects load-use hazards, requests an upstream stall, and inserts bubbles on flush or hazard.

Parameters:
DATA_W, 32, datapath width
REG_W, 5, register-number width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_rs_data  in  DATA_W  rs read value (for SLL/SRL, ID places rt value/number on rs lanes)
id_rt_data  in  DATA_W  rt read value
id_rs, id_rt, id_rd  in  REG_W each  register numbers
id_imm  in  16  immediate field
id_signext  in  1  1 = sign-extend imm, 0 = zero-extend
id_shamt  in  5  shift amount
id_aluop  in  3  ALU opcode (0 add … 7 slt)
id_alusrc  in  1  1 = In2 is extended imm
id_regdst  in  1  1 = dest rd, 0 = dest rt
id_regwrite, id_memread, id_memwrite  in  1 each  controls
id_branch  in  2  00 none, 01 beq, 10 bne
stall  in  1  downstream hold
flush  in  1  kill the instruction being captured
exmem_regwrite  in  1 ; exmem_rd  in  REG_W ; exmem_result  in  DATA_W
memwb_regwrite  in  1 ; memwb_rd  in  REG_W ; memwb_result  in  DATA_W
hazard_stall  out  1  load-use: hold PC and IF/ID
ex_valid  out  1  EX holds a real instruction
In1, In2  out  DATA_W  ALU operands
ALUOP  out  3 ; shamt  out  5
ex_store_data  out  DATA_W  forwarded rt for SW
ex_dest  out  REG_W  write-back register
ex_regwrite, ex_memread, ex_memwrite  out  1 each ; ex_branch  out  2

Behaviour:
- Single clock, rising edge. Reset is synchronous, active-low (rst_n).
- Reset (rst_n=0 at an edge): every registered field = 0; ex_valid=0; controls=0; ALUOP=0; In1/In2 then reflect zero data. Reset mid-stall or mid-flush discards everything.
- Update priority per edge: reset > flush > stall (hold) > hazard bubble > load.
  - Flush: load bubble (ex_valid=0, all controls 0, ex_dest=0). Flush beats stall.
  - Stall: all registers hold. Forwarding muxes keep evaluating combinationally.
  - Bubble: same as flush. The instruction stays in ID because hazard_stall=1.
- Load-use detection:
  - hazard_stall = id_valid & ex_valid & ex_memread & (ex_dest!=0) & ((ex_dest==id_rs) | (ex_dest==id_rt & uses_rt)).
  - uses_rt = !id_alusrc | id_memwrite | (id_branch!=0).
  - hazard_stall is combinational and forced 0 while flush=1.
- Forwarding, per registered source reg R (rs, then rt):
  - If exmem_regwrite & exmem_rd!=0 & exmem_rd==R, use exmem_result.
  - Else if memwb_regwrite & memwb_rd!=0 & memwb_rd==R, use memwb_result.
  - Else use the registered read data. EX/MEM always wins over MEM/WB.
  - R==0 never forwards, so $0 stays 0.
- Operands:
  - In1 = fwd_rs.
  - In2 = alusrc ? ext_imm : fwd_rt. ext_imm = {16{imm[15]&signext}, imm}.
  - ex_store_data = fwd_rt, independent of alusrc.
- ex_dest = regdst ? rd : rt, resolved at capture.
- ALUOP and shamt are passed registered, unchanged.
- Latency: ID fields appear at EX outputs one cycle after capture. Forwarded values reach In1/In2 in the same cycle.
- No same-cycle register-file bypass here; the register file does write-before-read.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1 and random inputs → ex_valid=0, all ex_* controls 0, ALUOP=0, ex_dest=0, hazard_stall=0.
- Pass-through: ADDI with rs_data=5, imm=16'hFFFE, signext=1, alusrc=1, aluop=0 → next cycle In1=5, In2=32'hFFFF_FFFE, ALUOP=0. Repeat with signext=0 → In2=32'h0000_FFFE.
- Forward priority: EX holds rs=3. Drive exmem_rd=3 with exmem_result=0xAA, and memwb_rd=3 with memwb_result=0xBB, both regwrite=1 → In1=0xAA. Drop exmem_regwrite → In1=0xBB. Set both rd=0 → In1 = registered rs_data.
- Load-use: EX holds LW with dest=8; ID holds ADD with rs=8 → hazard_stall=1. Next edge: ex_valid=0 bubble. Next cycle hazard_stall=0, ADD captured, then In1 = memwb_result when memwb_rd=8.
- Stall/flush: stall=1 for 3 cycles with changing ID inputs → outputs constant. Assert stall=1 and flush=1 together → ex_valid=0 after the edge.
- SW store data: alusrc=1, rt=9, exmem_rd=9, exmem_result=0x1234 → In2=ext_imm, ex_store_data=0x1234.
